// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, imem handshake, redirects, IF/ID feed
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] EXC_VEC  = 32'h80000004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        exception,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ReadInst,
    output logic [31:0] IF_PC_Plus_4,
    output logic        inst_valid,
    output logic        if_flush
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        drop, drop_n;
    logic [31:0] inst_buf, inst_buf_n;
    logic [31:0] pc_plus_4, pc_plus_4_n;
    logic        redirect;
    logic [31:0] target;

    // Redirect select: exception beats jump beats branch.
    always_comb begin
        redirect = exception | jump | branch_taken;
        target   = branch_target;
        if (exception) begin
            target = EXC_VEC;
        end else if (jump) begin
            target = jump_target;
        end
    end

    // Next-state, PC update and handshake outputs.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        inst_buf_n  = inst_buf;
        pc_plus_4_n = pc_plus_4;
        imem_req    = 1'b0;
        inst_valid  = 1'b0;
        case (state)
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_n = target;
                end
                if (imem_gnt) begin
                    state_n = ST_WAIT;
                    // The granted request is for the old PC, so its data must be thrown away.
                    if (redirect) begin
                        drop_n = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_n = target;
                end
                if (imem_rvalid) begin
                    drop_n  = 1'b0;
                    state_n = ST_REQ;
                    if (!drop && !redirect) begin
                        inst_buf_n  = imem_rdata;
                        pc_plus_4_n = pc + 32'd4;
                        state_n     = ST_FULL;
                    end
                end else if (redirect) begin
                    drop_n = 1'b1;
                end
            end
            ST_FULL: begin
                inst_valid = 1'b1;
                if (redirect) begin
                    pc_n    = target;
                    state_n = ST_REQ;
                end else if (!hold) begin
                    // IF/ID captures the buffered instruction at this edge.
                    pc_n    = pc + 32'd4;
                    state_n = ST_REQ;
                end
            end
            default: begin
                state_n = ST_REQ;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            inst_buf  <= 32'd0;
            pc_plus_4 <= 32'd0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            inst_buf  <= inst_buf_n;
            pc_plus_4 <= pc_plus_4_n;
        end
    end

    // Presented values hold while not FULL; if_flush masks them.
    always_comb begin
        imem_addr    = pc;
        ReadInst     = inst_buf;
        IF_PC_Plus_4 = pc_plus_4;
        if_flush     = !inst_valid || redirect;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        exception;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ReadInst;
    logic [31:0] IF_PC_Plus_4;
    logic        inst_valid;
    logic        if_flush;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic        prev_valid = 1'b0;

    if_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .exception    (exception),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ReadInst     (ReadInst),
        .IF_PC_Plus_4 (IF_PC_Plus_4),
        .inst_valid   (inst_valid),
        .if_flush     (if_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pop one expected instruction each time a new valid instruction appears.
    always @(negedge clk) begin
        #2;
        if (!reset && inst_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_read_inst", ReadInst, e[63:32]);
                check("sb_pc_plus_4", IF_PC_Plus_4, e[31:0]);
            end
        end
        prev_valid = inst_valid;
    end

    // From REQ at addr, grant now and return data next cycle; ends in FULL.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        #1;
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = data;
        exp_q.push_back({data, addr + 32'd4});
        step();
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        #1;
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, "_flush"}, {31'd0, if_flush}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 32'd0; branch_target = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        step();
        #1;
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", ReadInst, 32'd0);
        check("rst_pc4", IF_PC_Plus_4, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_flush", {31'd0, if_flush}, 32'd1);

        // First fetch, then hold in FULL for 3 cycles.
        fetch("f0", 32'h0, 32'h8C010004);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("hold_valid", {31'd0, inst_valid}, 32'd1);
            check("hold_inst", ReadInst, 32'h8C010004);
            check("hold_pc4", IF_PC_Plus_4, 32'd4);
            check("hold_req", {31'd0, imem_req}, 32'd0);
            check("hold_flush", {31'd0, if_flush}, 32'd0);
        end
        hold = 1'b0;
        step();
        #1;
        check("after_hold_addr", imem_addr, 32'd4);
        check("after_hold_valid", {31'd0, inst_valid}, 32'd0);

        // Jump while waiting for data: stale response discarded.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        jump = 1'b1; jump_target = 32'h00000100;
        #1;
        check("wait_redir_flush", {31'd0, if_flush}, 32'd1);
        step();
        jump = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
        step();
        imem_rvalid = 1'b0;
        #1;
        check("stale_valid", {31'd0, inst_valid}, 32'd0);
        check("stale_addr", imem_addr, 32'h100);

        // Branch in REQ without grant: stay in REQ at new target.
        branch_taken = 1'b1; branch_target = 32'h00000200;
        step();
        branch_taken = 1'b0;
        #1;
        check("req_redir_addr", imem_addr, 32'h200);

        // Jump coincident with grant: the granted fetch is dropped.
        jump = 1'b1; jump_target = 32'h00000300; imem_gnt = 1'b1;
        step();
        jump = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h22222222;
        step();
        imem_rvalid = 1'b0;
        #1;
        check("gnt_redir_valid", {31'd0, inst_valid}, 32'd0);
        check("gnt_redir_addr", imem_addr, 32'h300);

        // All three redirects in FULL under hold: exception wins.
        fetch("f1", 32'h300, 32'h33333333);
        hold = 1'b1; exception = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jump_target = 32'h00000400; branch_target = 32'h00000500;
        #1;
        check("exc_flush", {31'd0, if_flush}, 32'd1);
        step();
        hold = 1'b0; exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        #1;
        check("exc_valid", {31'd0, inst_valid}, 32'd0);
        check("exc_addr", imem_addr, 32'h80000004);

        // PC wrap at the top of the address space.
        jump = 1'b1; jump_target = 32'hFFFFFFFC;
        step();
        jump = 1'b0;
        fetch("fwrap", 32'hFFFFFFFC, 32'h44444444);
        check("wrap_pc4", IF_PC_Plus_4, 32'd0);
        step();
        #1;
        check("wrap_addr", imem_addr, 32'd0);

        // Reset while waiting; late rvalid is ignored.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
        step();
        imem_rvalid = 1'b0;
        #1;
        check("late_rv_valid", {31'd0, inst_valid}, 32'd0);
        check("late_rv_addr", imem_addr, 32'h0);
        check("late_rv_req", {31'd0, imem_req}, 32'd1);

        // Normal fetch still works afterwards.
        fetch("f2", 32'h0, 32'h66666666);
        step();
        #1;
        check("f2_next_addr", imem_addr, 32'd4);

        step();
        check("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
